control_ascensor: RTL
=====================

# control_ascensor

Elevator motion controller for the four-floor (0–3) car. It latches floor calls, schedules service using collective (same-direction-first) ordering, and times floor-to-floor travel and door dwell. Its registered outputs `piso`, `accion` and `puertas` drive the display encoder and use that encoder's encodings exactly.

## Interface

- `TRAVEL_CYCLES`, 100000000: clock cycles spent moving between adjacent floors; must be ≥2.
- `DOOR_CYCLES`, 200000000: clock cycles the doors stay open; must be ≥2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `llamada` in 4: floor call requests, one bit per floor; a bit is sampled on every edge it is high (cabin and hall buttons ORed upstream).
- `obstaculo` in 1: door obstruction; high holds the doors open.
- `piso` out 2: current floor (0–3).
- `accion` out 2: motion state. 0 = stopped, 1 = up, 2 = down; 3 is never driven.
- `puertas` out 1: door state. 0 = closed, 1 = open.
- `pendientes` out 4: latched calls not yet serviced.

## Operation

- States:
  - IDLE: `accion`=0, `puertas`=0.
  - SUBE: `accion`=1, `puertas`=0.
  - BAJA: `accion`=2, `puertas`=0.
  - PUERTA: `accion`=0, `puertas`=1.
- Internal registers: direction flag `dir` (up/down, reset up) and one shared timer, 32 bits wide, cleared on every state entry.
- Call latch:
  - `pendientes[i]` is set on any edge with `llamada[i]`=1.
  - It is cleared on the edge that enters PUERTA at floor i.
  - While in PUERTA, `llamada[piso]`=1 does not set the bit; it reloads the door timer instead. Clear wins over set.
- "Above" means any `pendientes` bit with index > `piso`; "below" means any bit with index < `piso`.
- IDLE, evaluated in priority order:
  1. `pendientes[piso]` → PUERTA.
  2. Calls both above and below → SUBE if `dir`=up, else BAJA.
  3. Calls above only → SUBE, `dir`=up.
  4. Calls below only → BAJA, `dir`=down.
  5. Otherwise stay in IDLE.
- SUBE/BAJA:
  - The timer counts every cycle.
  - On the edge where timer = TRAVEL_CYCLES−1, `piso` moves ±1 and the next state is chosen using the new floor:
    - call latched at the new floor → PUERTA (bit cleared);
    - else calls further in the same direction → same state, timer reset;
    - else → IDLE.
  - `piso` never leaves 0–3. SUBE is only entered with a call above and BAJA only with a call below; at floor 3 SUBE falls to IDLE, at floor 0 BAJA falls to IDLE.
- PUERTA:
  - The timer counts every cycle.
  - `obstaculo`=1 or `llamada[piso]`=1 reloads the timer to 0.
  - On the edge where timer = DOOR_CYCLES−1 (with no reload that cycle) → IDLE. IDLE re-evaluates on the following edge.
- Calls arriving in any state are latched and do not alter the travel currently in progress, except through the arrival rule above.

## Timing

- All outputs are registered and change only on `clk` rising edges, except on reset.
- Reset (`rst`=0), applied immediately and asynchronously:
  - `piso`=0, `accion`=0, `puertas`=0, `pendientes`=0;
  - state IDLE, `dir`=up, timer=0.
- Reset mid-travel or mid-door drops the state at once; the position is taken as floor 0.
- Call to motion latency: a call sampled at edge N appears in `pendientes` after N; state change (`accion`≠0 or `puertas`=1) appears after edge N+1.
- Each floor traversed keeps `accion` non-zero for exactly TRAVEL_CYCLES cycles.
- Uninterrupted door dwell keeps `puertas`=1 for exactly DOOR_CYCLES cycles, followed by at least one IDLE cycle.
- `accion` and `puertas` are never non-zero simultaneously.

## Test plan

All scenarios use `TRAVEL_CYCLES`=4, `DOOR_CYCLES`=3, starting from reset at floor 0.

- **Async reset:** drive `rst`=0 between edges during SUBE → `piso`=0, `accion`=0, `puertas`=0, `pendientes`=0000 immediately, with no clock edge needed.
- **Call at current floor:** one-cycle `llamada`=0001 in IDLE at floor 0 → `pendientes`=0001 for one cycle, then `puertas`=1 for 3 cycles with `pendientes`=0000 and `accion`=0 throughout, then IDLE.
- **Full run up:** one-cycle `llamada`=1000 → `accion`=1 for 12 cycles, with `piso` stepping 1→2→3 every 4 cycles, then `puertas`=1 for 3 cycles, `pendientes`=0000, end in IDLE at `piso`=3.
- **Intermediate stop:** `llamada`=1010 at floor 0 → stop at `piso`=1 with doors open 3 cycles and `pendientes`=1000, then travel up 8 cycles, stop at floor 3, `pendientes`=0000.
- **Direction preference:** at floor 2 after an upward trip (`dir`=up), latch 0001 and 1000 in the same cycle → go up to 3 and service it, then BAJA for 12 cycles down to 0 and service it.
- **Door hold:** hold `obstaculo`=1 for 5 cycles after PUERTA entry → `puertas` stays 1 until 3 cycles after `obstaculo` falls. A `llamada[piso]` pulse during PUERTA likewise extends the dwell and never sets `pendientes`.

Source files
------------

// File: rtl/control_ascensor.sv
// control_ascensor: four-floor elevator controller with collective call scheduling.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   llamada    : per-floor call requests (cabin and hall ORed upstream)
//   obstaculo  : door obstruction, holds the doors open while high
//   piso       : current floor 0..3
//   accion     : 0 stopped, 1 up, 2 down
//   puertas    : 0 closed, 1 open
//   pendientes : latched calls not yet serviced
module control_ascensor #(
    parameter int unsigned TRAVEL_CYCLES = 100000000,
    parameter int unsigned DOOR_CYCLES   = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] llamada,
    input  logic       obstaculo,
    output logic [1:0] piso,
    output logic [1:0] accion,
    output logic       puertas,
    output logic [3:0] pendientes
);
    typedef enum logic [1:0] {IDLE, SUBE, BAJA, PUERTA} state_t;
    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  piso_q, piso_d, nxt;
    logic [3:0]  pend_q, pend_d, clr, set;
    logic [1:0]  accion_q, accion_d;
    logic        puertas_q, puertas_d;
    logic        above, below;

    function automatic logic any_above(input logic [3:0] p, input logic [1:0] f);
        // Mask of indices strictly greater than f; wraps to empty at f=3.
        return |(p & ~((4'd2 << f) - 4'd1));
    endfunction

    function automatic logic any_below(input logic [3:0] p, input logic [1:0] f);
        return |(p & ((4'd1 << f) - 4'd1));
    endfunction

    assign above = any_above(pend_q, piso_q);
    assign below = any_below(pend_q, piso_q);
    assign nxt   = (state_q == SUBE) ? piso_q + 2'd1 : piso_q - 2'd1;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q + 32'd1;
        piso_d  = piso_q;
        clr     = 4'd0;
        case (state_q)
            IDLE: begin
                timer_d = 32'd0;
                if (pend_q[piso_q]) begin
                    state_d     = PUERTA;
                    clr[piso_q] = 1'b1;
                end else if (above && below) begin
                    state_d = dir_q ? SUBE : BAJA;
                end else if (above) begin
                    state_d = SUBE;
                    dir_d   = 1'b1;
                end else if (below) begin
                    state_d = BAJA;
                    dir_d   = 1'b0;
                end
            end
            SUBE, BAJA: begin
                if (timer_q == 32'(TRAVEL_CYCLES - 1)) begin
                    piso_d  = nxt;
                    timer_d = 32'd0;
                    if (pend_q[nxt]) begin
                        state_d  = PUERTA;
                        clr[nxt] = 1'b1;
                    end else if (!((state_q == SUBE) ? any_above(pend_q, nxt) : any_below(pend_q, nxt))) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                if (obstaculo || llamada[piso_q]) begin
                    timer_d = 32'd0;
                end else if (timer_q == 32'(DOOR_CYCLES - 1)) begin
                    state_d = IDLE;
                    timer_d = 32'd0;
                end
            end
        endcase
        // A call for the floor whose doors are open only extends the dwell.
        set       = llamada & ~((state_q == PUERTA) ? (4'd1 << piso_q) : 4'd0);
        pend_d    = (pend_q | set) & ~clr;
        accion_d  = (state_d == SUBE) ? 2'd1 : (state_d == BAJA) ? 2'd2 : 2'd0;
        puertas_d = (state_d == PUERTA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dir_q     <= 1'b1;
            timer_q   <= 32'd0;
            piso_q    <= 2'd0;
            pend_q    <= 4'd0;
            accion_q  <= 2'd0;
            puertas_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            piso_q    <= piso_d;
            pend_q    <= pend_d;
            accion_q  <= accion_d;
            puertas_q <= puertas_d;
        end
    end

    assign piso       = piso_q;
    assign accion     = accion_q;
    assign puertas    = puertas_q;
    assign pendientes = pend_q;
endmodule
